present_key_sched_seq: RTL and testbench
========================================

// Module: present_key_sched_seq
// PURPOSE
//  Sequential PRESENT key-schedule engine, parametrised for 80- or 128-bit keys.
//  Accepts a master key over a valid/ready handshake, then issues round keys K1..K(NUM_ROUNDS+1) one per accepted beat.
//  Also reports the final key-register state, which seeds decryption.
//  Sits between the key loader and the round datapath; the datapath may stall it.
// PARAMETERS
//  KEY_SIZE    80   master key width; legal values 80 and 128 only (elaboration error otherwise)
//  NUM_ROUNDS  31   round count; issues NUM_ROUNDS+1 round keys
//  RK_WIDTH    64   round-key width = key_reg[KEY_SIZE-1 -: RK_WIDTH]
//  CNT_W       5    round-counter width; must satisfy 2**CNT_W > NUM_ROUNDS
// PORTS
//  clk         in   1         single clock, rising edge
//  rst         in   1         synchronous reset, active-high
//  key_in      in   KEY_SIZE  master key
//  key_valid   in   1         key_in is valid
//  key_ready   out  1         engine idle; key accepted on key_valid&&key_ready
//  rk_out      out  RK_WIDTH  current round key
//  rk_idx      out  CNT_W+1   index of rk_out, 1..NUM_ROUNDS+1
//  rk_valid    out  1         rk_out/rk_idx are valid
//  rk_ready    in   1         consumer accepts on rk_valid&&rk_ready
//  rk_last     out  1         high with rk_valid when rk_idx==NUM_ROUNDS+1
//  final_key   out  KEY_SIZE  key register after the last update (decryption seed)
//  final_valid out  1         one-cycle pulse when final_key is updated
//  busy        out  1         state != IDLE
// BEHAVIOUR
//  Reset (sync, rst=1 at an edge): state=IDLE, key_reg=0, rk_idx=1, final_key=0, final_valid=0.
//   After reset: key_ready=1, rk_valid=0.
//  States: IDLE -> RUN -> IDLE. key_ready=(state==IDLE); rk_valid=(state==RUN).
//   rk_out is taken from key_reg combinationally.
//  IDLE: on key_valid&&key_ready: key_reg<=key_in, rk_idx<=1, go RUN.
//   key_valid without ready has no effect.
//  RUN, no handshake (rk_ready=0): hold key_reg and rk_idx; rk_out stable (AXI-style).
//  RUN, handshake with rk_idx<=NUM_ROUNDS: key_reg<=upd(key_reg, rk_idx); rk_idx++.
//  RUN, handshake with rk_idx==NUM_ROUNDS+1: final_key<=key_reg; final_valid=1 next cycle; go IDLE.
//  Latency: key accepted at edge N -> rk_valid=1 from cycle N+1.
//   With rk_ready tied 1: NUM_ROUNDS+1 consecutive beats, then key_ready=1 again the cycle after rk_last.
//   No back-to-back overlap: a new key is never accepted in the same cycle as rk_last.
//  upd(k,i), KEY_SIZE=80: r = rotl(k,61); r[79:76]=S(r[79:76]); r[19:15]^=i[4:0].
//  upd(k,i), KEY_SIZE=128: r = rotl(k,61); r[127:124]=S(r[127:124]); r[123:120]=S(r[123:120]); r[66:62]^=i[4:0].
//  Counter XOR uses the index of the key being consumed, truncated to 5 bits; no wrap occurs for NUM_ROUNDS<=31.
//  rst during RUN: abandons the sequence next edge; no rk_last, no final_valid.
//  rk_ready asserted while rk_valid=0: ignored.
// STRUCTURE
//  Shared package present_pkg:
//   - KEY80/KEY128 localparams, ROT_AMT=61
//   - typedef enum {IDLE, RUN} ks_state_t
//   - function present_sbox (4-bit PRESENT S-box table)
//  One sub-module: present_sbox4 (combinational 4->4).
//   Instantiated once for 80-bit keys, twice for 128-bit keys (generate on KEY_SIZE).
//  Update logic is a pure function; all state lives in a single always_ff.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> key_ready=1, rk_valid=0, final_valid=0, rk_idx=1.
//  2 KEY_SIZE=80, key=0, rk_ready=1 -> K1=0x0000_0000_0000_0000, K2=0xC000_0000_0000_0000;
//    K1..K32 and final_key match the team's software golden model; rk_last only on idx 32.
//  3 KEY_SIZE=128, key=0 -> K2=0xCC00_0000_0000_0000; full sequence matches golden model.
//  4 Random rk_ready (50%) during RUN -> rk_out/rk_idx held while stalled; same 32-key sequence as test 2.
//  5 key_valid held high throughout -> second key accepted only the cycle after rk_last.
//  6 rst at rk_idx=10 -> next cycle IDLE, rk_valid=0, no final_valid;
//    a following key runs a full sequence from idx 1.

Source files
------------

// File: rtl/present_pkg.sv
// Shared PRESENT definitions: key-size constants, key-schedule FSM states and the 4-bit S-box.
package present_pkg;

    localparam int unsigned KEY80   = 80;
    localparam int unsigned KEY128  = 128;
    localparam int unsigned ROT_AMT = 61;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_t;

    function automatic logic [3:0] present_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/present_sbox4.sv
// Combinational PRESENT 4-bit S-box.
module present_sbox4
    import present_pkg::*;
(
    input  logic [3:0] x,
    output logic [3:0] y_c
);

    assign y_c = present_sbox(x);

endmodule

// File: rtl/present_key_sched_seq.sv
// Sequential PRESENT key schedule: loads a master key, then streams round keys K1..K(NUM_ROUNDS+1)
// under valid/ready flow control and reports the final key register as the decryption seed.
module present_key_sched_seq
    import present_pkg::*;
#(
    parameter int unsigned KEY_SIZE   = 80,
    parameter int unsigned NUM_ROUNDS = 31,
    parameter int unsigned RK_WIDTH   = 64,
    parameter int unsigned CNT_W      = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_SIZE-1:0] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    output logic [RK_WIDTH-1:0] rk_out,
    output logic [CNT_W:0]      rk_idx,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic                rk_last,
    output logic [KEY_SIZE-1:0] final_key,
    output logic                final_valid,
    output logic                busy
);

    localparam int unsigned IDX_W   = CNT_W + 1;
    localparam int unsigned XOR_LSB = (KEY_SIZE == KEY128) ? 62 : 15;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS + 1);

    if ((KEY_SIZE != KEY80) && (KEY_SIZE != KEY128)) begin : g_bad_key_size
        $error("present_key_sched_seq: KEY_SIZE must be 80 or 128");
    end
    if ((2 ** CNT_W) <= NUM_ROUNDS) begin : g_bad_cnt_w
        $error("present_key_sched_seq: CNT_W too narrow for NUM_ROUNDS");
    end
    if (RK_WIDTH > KEY_SIZE) begin : g_bad_rk_width
        $error("present_key_sched_seq: RK_WIDTH exceeds KEY_SIZE");
    end

    ks_state_t           state_q, state_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [KEY_SIZE-1:0] final_q, final_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                fv_q, fv_d;
    logic [KEY_SIZE-1:0] rot_c, upd_c;
    logic [3:0]          sb_hi_c;

    // Next key = rotl(key, 61), S-box on the top nibble(s), round index folded into the middle.
    assign rot_c = {key_q[KEY_SIZE-ROT_AMT-1:0], key_q[KEY_SIZE-1:KEY_SIZE-ROT_AMT]};

    present_sbox4 u_sbox_hi (
        .x   (rot_c[KEY_SIZE-1 -: 4]),
        .y_c (sb_hi_c)
    );

    if (KEY_SIZE == KEY128) begin : g_k128
        logic [3:0] sb_lo_c;

        present_sbox4 u_sbox_lo (
            .x   (rot_c[KEY_SIZE-5 -: 4]),
            .y_c (sb_lo_c)
        );

        always_comb begin
            upd_c                    = rot_c;
            upd_c[KEY_SIZE-1 -: 4]   = sb_hi_c;
            upd_c[KEY_SIZE-5 -: 4]   = sb_lo_c;
            upd_c[XOR_LSB +: 5]      = rot_c[XOR_LSB +: 5] ^ 5'(idx_q);
        end
    end else begin : g_k80
        always_comb begin
            upd_c                    = rot_c;
            upd_c[KEY_SIZE-1 -: 4]   = sb_hi_c;
            upd_c[XOR_LSB +: 5]      = rot_c[XOR_LSB +: 5] ^ 5'(idx_q);
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        final_d = final_q;
        fv_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    key_d   = key_in;
                    idx_d   = IDX_W'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        final_d = key_q;
                        fv_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        key_d = upd_c;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= IDX_W'(1);
            final_q <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            final_q <= final_d;
            fv_q    <= fv_d;
        end
    end

    assign key_ready   = (state_q == IDLE);
    assign rk_valid    = (state_q == RUN);
    assign busy        = (state_q != IDLE);
    assign rk_out      = key_q[KEY_SIZE-1 -: RK_WIDTH];
    assign rk_idx      = idx_q;
    assign rk_last     = (state_q == RUN) && (idx_q == LAST_IDX);
    assign final_key   = final_q;
    assign final_valid = fv_q;

endmodule

// File: tb/tb_present_key_sched_seq.sv
// Scoreboard bench: 80- and 128-bit engines run in lockstep against a behavioural key-schedule model.
module tb_present_key_sched_seq;

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic         rk_ready;
    logic [79:0]  key80;
    logic [127:0] key128;

    logic         key_ready80, rk_valid80, rk_last80, fv80, busy80;
    logic [63:0]  rk_out80;
    logic [5:0]   rk_idx80;
    logic [79:0]  final_key80;

    logic         key_ready128, rk_valid128, rk_last128, fv128, busy128;
    logic [63:0]  rk_out128;
    logic [5:0]   rk_idx128;
    logic [127:0] final_key128;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [63:0] rk;
        bit          last;
    } exp_t;

    exp_t         q80[$];
    exp_t         q128[$];
    logic [79:0]  f80[$];
    logic [127:0] f128[$];
    bit           exp_busy = 0;
    bit           exp_fv   = 0;

    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    present_key_sched_seq #(.KEY_SIZE(80), .NUM_ROUNDS(31), .RK_WIDTH(64), .CNT_W(5)) dut80 (
        .clk(clk), .rst(rst), .key_in(key80), .key_valid(key_valid), .key_ready(key_ready80),
        .rk_out(rk_out80), .rk_idx(rk_idx80), .rk_valid(rk_valid80), .rk_ready(rk_ready),
        .rk_last(rk_last80), .final_key(final_key80), .final_valid(fv80), .busy(busy80)
    );

    present_key_sched_seq #(.KEY_SIZE(128), .NUM_ROUNDS(31), .RK_WIDTH(64), .CNT_W(5)) dut128 (
        .clk(clk), .rst(rst), .key_in(key128), .key_valid(key_valid), .key_ready(key_ready128),
        .rk_out(rk_out128), .rk_idx(rk_idx128), .rk_valid(rk_valid128), .rk_ready(rk_ready),
        .rk_last(rk_last128), .final_key(final_key128), .final_valid(fv128), .busy(busy128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expand a master key into 32 round keys plus the final register value.
    function automatic void model80(input logic [79:0] k0);
        logic [79:0] k = k0;
        for (int i = 1; i <= 32; i++) begin
            q80.push_back('{i, k[79:16], (i == 32)});
            if (i < 32) begin
                k = (k << 61) | (k >> 19);
                k[79:76] = SBOX[k[79:76]];
                k[19:15] = k[19:15] ^ 5'(i);
            end
        end
        f80.push_back(k);
    endfunction

    function automatic void model128(input logic [127:0] k0);
        logic [127:0] k = k0;
        for (int i = 1; i <= 32; i++) begin
            q128.push_back('{i, k[127:64], (i == 32)});
            if (i < 32) begin
                k = (k << 61) | (k >> 67);
                k[127:124] = SBOX[k[127:124]];
                k[123:120] = SBOX[k[123:120]];
                k[66:62]   = k[66:62] ^ 5'(i);
            end
        end
        f128.push_back(k);
    endfunction

    // Monitor: compares DUT outputs with the scoreboard heads, advancing on handshakes.
    always @(negedge clk) begin
        exp_t e8, e12;
        if (rst) begin
            q80.delete();
            q128.delete();
            f80.delete();
            f128.delete();
            exp_busy = 0;
            exp_fv   = 0;
        end else begin
            chk("key_ready80", 128'(key_ready80), 128'(!exp_busy));
            chk("key_ready128", 128'(key_ready128), 128'(!exp_busy));
            chk("rk_valid80", 128'(rk_valid80), 128'(exp_busy));
            chk("rk_valid128", 128'(rk_valid128), 128'(exp_busy));
            chk("final_valid80", 128'(fv80), 128'(exp_fv));
            chk("final_valid128", 128'(fv128), 128'(exp_fv));
            if (exp_fv && f80.size() > 0 && f128.size() > 0) begin
                chk("final_key80", 128'(final_key80), 128'(f80.pop_front()));
                chk("final_key128", final_key128, f128.pop_front());
            end
            exp_fv = 0;
            if (exp_busy) begin
                if (q80.size() == 0 || q128.size() == 0) begin
                    chk("scoreboard_underflow", 128'(1), 128'(0));
                    exp_busy = 0;
                end else begin
                    e8  = q80[0];
                    e12 = q128[0];
                    chk("rk_out80", 128'(rk_out80), 128'(e8.rk));
                    chk("rk_idx80", 128'(rk_idx80), 128'(e8.idx));
                    chk("rk_last80", 128'(rk_last80), 128'(e8.last));
                    chk("rk_out128", 128'(rk_out128), 128'(e12.rk));
                    chk("rk_idx128", 128'(rk_idx128), 128'(e12.idx));
                    chk("rk_last128", 128'(rk_last128), 128'(e12.last));
                    if (rk_ready) begin
                        void'(q80.pop_front());
                        void'(q128.pop_front());
                        if (e8.last) begin
                            exp_busy = 0;
                            exp_fv   = 1;
                        end
                    end
                end
            end else if (key_valid) begin
                model80(key80);
                model128(key128);
                exp_busy = 1;
            end
        end
    end

    task automatic wait_idle(input bit rand_ready);
        bit done = 0;
        for (int c = 0; c < 1000; c++) begin
            if (!busy80 && !busy128 && q80.size() == 0 && !exp_busy) begin
                done = 1;
                break;
            end
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
        end
        if (!done) chk("wait_idle_timeout", 128'(1), 128'(0));
        rk_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_key(input logic [79:0] k8, input logic [127:0] k12);
        key80     = k8;
        key128    = k12;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    initial begin
        bit hit;
        rst = 1'b1; key_valid = 1'b0; rk_ready = 1'b0; key80 = '0; key128 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rk_idx80", 128'(rk_idx80), 128'(1));
        chk("reset_rk_idx128", 128'(rk_idx128), 128'(1));

        // All-zero key with known first round keys.
        @(posedge clk); #1;
        rk_ready = 1'b1;
        send_key('0, '0);
        @(negedge clk);
        chk("kat_k1_80", 128'(rk_out80), 128'(0));
        chk("kat_k1_128", 128'(rk_out128), 128'(0));
        @(negedge clk);
        chk("kat_k2_80", 128'(rk_out80), 128'(64'hC000_0000_0000_0000));
        chk("kat_k2_128", 128'(rk_out128), 128'(64'hCC00_0000_0000_0000));
        wait_idle(1'b0);

        // Random keys under random consumer stalls.
        for (int n = 0; n < 3; n++) begin
            send_key({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, $urandom, $urandom});
            wait_idle(1'b1);
        end

        // key_valid held high with a fresh key every cycle.
        key_valid = 1'b1;
        for (int c = 0; c < 150; c++) begin
            key80    = {$urandom, $urandom, 16'($urandom)};
            key128   = {$urandom, $urandom, $urandom, $urandom};
            rk_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        wait_idle(1'b0);

        // Reset in the middle of a sequence, then a clean full run.
        rk_ready = 1'b1;
        send_key({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, $urandom, $urandom});
        hit = 0;
        for (int c = 0; c < 100; c++) begin
            if (rk_idx80 == 6'd10) begin
                hit = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reach_idx10", 128'(hit), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_rk_valid80", 128'(rk_valid80), 128'(0));
        chk("abort_rk_idx80", 128'(rk_idx80), 128'(1));
        chk("abort_final_valid80", 128'(fv80), 128'(0));
        chk("abort_busy128", 128'(busy128), 128'(0));
        @(posedge clk); #1;
        send_key({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, $urandom, $urandom});
        wait_idle(1'b1);

        repeat (2) @(posedge clk);
        chk("q80_drained", 128'(q80.size()), 128'(0));
        chk("f80_drained", 128'(f80.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
